// File: rtl/i2c_target_regs.sv
// i2c_target_regs: oversampled I2C target with register-pointer read/write back end.
module i2c_target_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         AW         = 8,
    parameter int         SYNC       = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          i2c_scl,
    inout  wire           i2c_sda,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_wr,
    output logic          reg_rd,
    input  logic [7:0]    reg_rdata,
    output logic          busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
    } state_t;

    state_t          r_state, w_next;
    logic [SYNC-1:0] r_scl_sync, r_sda_sync;
    logic            r_scl_q, r_sda_q;
    logic [7:0]      r_shift;
    logic [3:0]      r_cnt;
    logic            r_ack_low, r_busy, r_wr;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_wdata;
    logic            w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
    logic            w_last, w_match, w_rx, w_ack, w_load, w_sda_low;
    logic [7:0]      w_byte;

    assign w_scl   = r_scl_sync[SYNC-1];
    assign w_sda   = r_sda_sync[SYNC-1];
    assign w_rise  = w_scl & ~r_scl_q;
    assign w_fall  = ~w_scl & r_scl_q;
    // SCL must be high on both samples, so START/STOP can never coincide with an SCL edge
    assign w_start = w_scl & r_scl_q & r_sda_q & ~w_sda;
    assign w_stop  = w_scl & r_scl_q & ~r_sda_q & w_sda;
    assign w_byte  = {r_shift[6:0], w_sda};
    assign w_last  = r_cnt == 4'd7;
    assign w_match = w_byte[7:1] == SLAVE_ADDR;
    assign w_rx    = r_state == S_ADDR || r_state == S_PTR || r_state == S_WDATA;
    assign w_ack   = r_state == S_ADDR_ACK || r_state == S_PTR_ACK || r_state == S_WDATA_ACK;
    // In ADDR_ACK the shift register still holds the address byte, so bit 0 is R/W
    assign w_load  = w_fall && ((r_state == S_ADDR_ACK && r_ack_low && r_shift[0]) ||
                                (r_state == S_RACK && r_cnt != 4'd0));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC-2:0], i2c_scl};
            r_sda_sync <= {r_sda_sync[SYNC-2:0], i2c_sda};
            r_scl_q    <= w_scl;
            r_sda_q    <= w_sda;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_stop) w_next = S_IDLE;
        else if (w_start) w_next = S_ADDR;
        else if (w_rise && w_rx && w_last)
            w_next = r_state == S_ADDR ? (w_match ? S_ADDR_ACK : S_IGNORE) :
                     r_state == S_PTR  ? S_PTR_ACK : S_WDATA_ACK;
        else if (w_fall && w_ack && r_ack_low)
            w_next = r_state != S_ADDR_ACK ? S_WDATA : r_shift[0] ? S_RDATA : S_PTR;
        else if (w_fall && r_state == S_RDATA && r_cnt == 4'd8) w_next = S_RACK;
        else if (w_rise && r_state == S_RACK && w_sda) w_next = S_IGNORE;
        else if (w_load && r_state == S_RACK) w_next = S_RDATA;
    end

    always_comb begin
        w_sda_low = !RESET && (r_ack_low || (r_state == S_RDATA && !r_shift[7]));
        reg_rd    = w_load && !RESET;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_ack_low <= 1'b0;
            r_busy    <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_wr <= 1'b0;
            if (r_wr) r_addr <= r_addr + AW'(1);
            if (w_stop || w_start) begin
                r_cnt     <= '0;
                r_ack_low <= 1'b0;
                if (w_stop) r_busy <= 1'b0;
            end else if (w_rise && w_rx) begin
                r_shift <= w_byte;
                r_cnt   <= w_last ? 4'd0 : r_cnt + 4'd1;
                if (w_last && r_state == S_ADDR) r_busy <= w_match;
                if (w_last && r_state == S_PTR) r_addr <= AW'(w_byte);
                if (w_last && r_state == S_WDATA) begin
                    r_wdata <= w_byte;
                    r_wr    <= 1'b1;
                end
            end else if (w_rise && r_state == S_RACK && !w_sda) begin
                r_addr <= r_addr + AW'(1);
                r_cnt  <= 4'd1;
            end else if (w_load) begin
                r_shift   <= reg_rdata;
                r_cnt     <= 4'd1;
                r_ack_low <= 1'b0;
            end else if (w_fall && w_ack) begin
                r_ack_low <= !r_ack_low;
                r_cnt     <= '0;
            end else if (w_fall && r_state == S_RDATA) begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_cnt   <= r_cnt == 4'd8 ? 4'd0 : r_cnt + 4'd1;
            end
        end
    end

    assign i2c_sda   = w_sda_low ? 1'b0 : 1'bz;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wr    = r_wr;
    assign busy      = r_busy;
endmodule
